// File: rtl/move_scheduler_if.sv
// Bundles the object request lines, checker handshake and status outputs of the move scheduler.
// master = scheduler side, slave = objects/checker/frame logic side.
interface move_scheduler_if #(
  parameter int NUM_OBJ = 4
);
  logic                   frame_tick;
  logic [NUM_OBJ-1:0]     move_req;
  logic [4*NUM_OBJ-1:0]   move_dir;
  logic                   chk_done;
  logic                   chk_blocked;
  logic                   chk_start;
  logic [2:0]             chk_obj;
  logic [3:0]             chk_dir;
  logic [NUM_OBJ-1:0]     grant;
  logic [NUM_OBJ-1:0]     reject;
  logic                   busy;
  logic                   timeout_err;
  logic [3:0]             moves_left;

  modport master (
    input  frame_tick, move_req, move_dir, chk_done, chk_blocked,
    output chk_start, chk_obj, chk_dir, grant, reject, busy, timeout_err, moves_left
  );

  modport slave (
    output frame_tick, move_req, move_dir, chk_done, chk_blocked,
    input  chk_start, chk_obj, chk_dir, grant, reject, busy, timeout_err, moves_left
  );
endinterface

// File: rtl/move_scheduler.sv
// Round-robin arbiter that funnels object move requests through one shared collision
// checker, with a per-frame cap on checker transactions and a WAIT watchdog.
//
// state | meaning
// IDLE  | look for a requester at/after rrPtr; needs budget left
// ISSUE | pulse chk_start, spend one move, arm the watchdog
// WAIT  | wait for chk_done or watchdog expiry
// RESP  | pulse grant or reject to the latched object
module move_scheduler #(
  parameter int NUM_OBJ   = 4,
  parameter int MAX_MOVES = 6,
  parameter int TIMEOUT   = 16
) (
  input  logic btnClk,
  input  logic rst,
  move_scheduler_if.master bus
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t     state, stateNext;
  logic [2:0] rrPtr;
  logic [2:0] chkObj;
  logic [3:0] chkDir;
  logic [3:0] movesLeft;
  logic [7:0] timer;
  logic       verdict;
  logic       timeoutErr;

  logic       anyHi, anyLo, found;
  logic [2:0] selHi, selLo, selIdx;
  logic [3:0] dirHi, dirLo, selDir;
  logic       dirValid;
  logic       launch;
  logic [NUM_OBJ-1:0] objMask;

  // Descending scan: the last hit is the lowest index, so selHi is the first
  // requester at/after rrPtr and selLo is the wrap-around fallback.
  always_comb begin
    anyHi = 1'b0;
    anyLo = 1'b0;
    selHi = '0;
    selLo = '0;
    dirHi = '0;
    dirLo = '0;
    for (int j = NUM_OBJ - 1; j >= 0; j--) begin
      if (bus.move_req[j]) begin
        anyLo = 1'b1;
        selLo = 3'(j);
        dirLo = bus.move_dir[4*j +: 4];
        if (j >= int'(rrPtr)) begin
          anyHi = 1'b1;
          selHi = 3'(j);
          dirHi = bus.move_dir[4*j +: 4];
        end
      end
    end
    found    = anyLo;
    selIdx   = anyHi ? selHi : selLo;
    selDir   = anyHi ? dirHi : dirLo;
    dirValid = $onehot(selDir);
  end

  assign launch = (state == IDLE) && found && (movesLeft != 4'd0);

  always_ff @(posedge btnClk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    case (state)
      IDLE:  if (launch) stateNext = dirValid ? ISSUE : RESP;
      ISSUE: stateNext = WAIT;
      WAIT:  if (bus.chk_done || timer == 8'd0) stateNext = RESP;
      RESP:  stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  // Watchdog is a down-counter loaded so that RESP lands exactly TIMEOUT
  // cycles after the chk_start pulse.
  always_ff @(posedge btnClk or posedge rst) begin
    if (rst) begin
      rrPtr      <= '0;
      chkObj     <= '0;
      chkDir     <= '0;
      timer      <= '0;
      verdict    <= 1'b0;
      timeoutErr <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (launch) begin
            chkObj  <= selIdx;
            chkDir  <= selDir;
            verdict <= ~dirValid;
          end
        end
        ISSUE: timer <= 8'(TIMEOUT - 2);
        WAIT: begin
          if (bus.chk_done) begin
            verdict <= bus.chk_blocked;
          end else if (timer == 8'd0) begin
            verdict    <= 1'b1;
            timeoutErr <= 1'b1;
          end else begin
            timer <= timer - 8'd1;
          end
        end
        RESP: rrPtr <= (chkObj == 3'(NUM_OBJ - 1)) ? 3'd0 : chkObj + 3'd1;
        default: ;
      endcase
    end
  end

  // frame_tick outranks the ISSUE decrement.
  always_ff @(posedge btnClk or posedge rst) begin
    if (rst)                                          movesLeft <= 4'(MAX_MOVES);
    else if (bus.frame_tick)                          movesLeft <= 4'(MAX_MOVES);
    else if (state == ISSUE && movesLeft != 4'd0)     movesLeft <= movesLeft - 4'd1;
  end

  assign objMask         = {{(NUM_OBJ-1){1'b0}}, 1'b1} << chkObj;
  assign bus.chk_start   = (state == ISSUE);
  assign bus.chk_obj     = chkObj;
  assign bus.chk_dir     = chkDir;
  assign bus.grant       = (state == RESP && !verdict) ? objMask : '0;
  assign bus.reject      = (state == RESP &&  verdict) ? objMask : '0;
  assign bus.busy        = (state != IDLE);
  assign bus.timeout_err = timeoutErr;
  assign bus.moves_left  = movesLeft;

endmodule

// File: tb/tb_move_scheduler.sv
// Directed bench for move_scheduler: handshake latency, round-robin order, budget,
// invalid direction, watchdog timeout and reset mid-transaction.
module tb_move_scheduler;

  localparam int NOBJ = 4;
  localparam int TMO  = 16;

  logic btnClk = 1'b0;
  logic rst;
  int   nAsserts = 0;
  int   nFail    = 0;

  move_scheduler_if #(.NUM_OBJ(NOBJ)) bus ();

  move_scheduler #(.NUM_OBJ(NOBJ), .MAX_MOVES(6), .TIMEOUT(TMO)) dut (
    .btnClk (btnClk),
    .rst    (rst),
    .bus    (bus.master)
  );

  always #5 btnClk = ~btnClk;

  task automatic tick();
    @(posedge btnClk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nAsserts++;
    assert (obs === exp) else begin
      nFail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic waitStart(input string tag, output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (bus.chk_start !== 1'b1 && n < 20);
    chk({tag, "_start_seen"}, 32'(bus.chk_start), 32'd1);
  endtask

  task automatic doReset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // Full transaction: request, checker answers d cycles after chk_start.
  task automatic serve(input string tag, input logic [3:0] req, input logic [15:0] dir,
                       input int d, input logic blocked, input logic [2:0] expObj,
                       input logic [3:0] expDir, input logic keep, output int lat);
    logic [3:0] mask;
    mask = 4'b0001 << expObj;
    bus.move_req = req;
    bus.move_dir = dir;
    waitStart(tag, lat);
    chk({tag, "_obj"}, 32'(bus.chk_obj), 32'(expObj));
    chk({tag, "_dir"}, 32'(bus.chk_dir), 32'(expDir));
    if (!keep) bus.move_req = '0;
    repeat (d) tick();
    bus.chk_done    = 1'b1;
    bus.chk_blocked = blocked;
    tick();
    chk({tag, "_grant"},  32'(bus.grant),  32'(blocked ? 4'b0000 : mask));
    chk({tag, "_reject"}, 32'(bus.reject), 32'(blocked ? mask : 4'b0000));
    bus.chk_done    = 1'b0;
    bus.chk_blocked = 1'b0;
    tick();
  endtask

  initial begin
    int lat;
    logic [3:0] acc;
    logic       sawStart;

    rst             = 1'b1;
    bus.frame_tick  = 1'b0;
    bus.move_req    = '0;
    bus.move_dir    = '0;
    bus.chk_done    = 1'b0;
    bus.chk_blocked = 1'b0;
    tick();
    tick();
    chk("rst_chk_start", 32'(bus.chk_start), 32'd0);
    chk("rst_grant",     32'(bus.grant),     32'd0);
    chk("rst_reject",    32'(bus.reject),    32'd0);
    chk("rst_busy",      32'(bus.busy),      32'd0);
    chk("rst_tmo",       32'(bus.timeout_err), 32'd0);
    chk("rst_obj_dir",   32'({bus.chk_obj, bus.chk_dir}), 32'd0);
    chk("rst_moves",     32'(bus.moves_left), 32'd6);
    rst = 1'b0;
    tick();

    // Single grant, checker answers 3 cycles after start.
    serve("t1", 4'b0001, 16'h0008, 3, 1'b0, 3'd0, 4'd8, 1'b0, lat);
    chk("t1_latency", 32'(lat), 32'd1);
    chk("t1_moves",   32'(bus.moves_left), 32'd5);
    chk("t1_idle",    32'(bus.busy), 32'd0);

    // Round robin over all objects until the budget runs out.
    doReset();
    for (int k = 0; k < 6; k++)
      serve($sformatf("t2_rr%0d", k), 4'b1111, 16'h2222, 1, 1'b0, 3'(k % 4), 4'd2, 1'b1, lat);
    chk("t2_moves_zero", 32'(bus.moves_left), 32'd0);
    sawStart = 1'b0;
    repeat (8) begin
      tick();
      sawStart = sawStart | bus.chk_start;
    end
    chk("t2_no_start_when_empty", 32'(sawStart), 32'd0);
    bus.frame_tick = 1'b1;
    tick();
    bus.frame_tick = 1'b0;
    chk("t2_refill", 32'(bus.moves_left), 32'd6);
    serve("t2_after_tick", 4'b1111, 16'h2222, 1, 1'b0, 3'd2, 4'd2, 1'b0, lat);
    chk("t2_moves_5", 32'(bus.moves_left), 32'd5);

    // Blocked move; frame_tick coincides with ISSUE and wins.
    bus.move_req = 4'b0010;
    bus.move_dir = 16'h0040;
    waitStart("t3", lat);
    chk("t3_obj", 32'(bus.chk_obj), 32'd1);
    bus.frame_tick = 1'b1;
    bus.move_req   = '0;
    tick();
    bus.frame_tick = 1'b0;
    chk("t3_tick_wins", 32'(bus.moves_left), 32'd6);
    bus.chk_done    = 1'b1;
    bus.chk_blocked = 1'b1;
    tick();
    chk("t3_reject", 32'(bus.reject), 32'b0010);
    chk("t3_grant",  32'(bus.grant),  32'd0);
    bus.chk_done    = 1'b0;
    bus.chk_blocked = 1'b0;
    tick();

    // rrPtr is now 2: objects 1 and 2 request, object 2 carries a non-one-hot dir.
    bus.move_req = 4'b0110;
    bus.move_dir = 16'h0640;
    tick();
    chk("t4_reject",   32'(bus.reject),    32'b0100);
    chk("t4_grant",    32'(bus.grant),     32'd0);
    chk("t4_no_start", 32'(bus.chk_start), 32'd0);
    chk("t4_dir",      32'(bus.chk_dir),   32'd6);
    chk("t4_moves",    32'(bus.moves_left), 32'd6);
    bus.move_req = '0;
    tick();

    // Checker never answers: reject exactly TMO cycles after chk_start.
    bus.move_req = 4'b1000;
    bus.move_dir = 16'h1000;
    waitStart("t5", lat);
    chk("t5_obj", 32'(bus.chk_obj), 32'd3);
    bus.move_req = '0;
    acc = '0;
    for (int i = 1; i < TMO; i++) begin
      tick();
      acc = acc | bus.reject | bus.grant;
    end
    chk("t5_no_early_resp", 32'(acc), 32'd0);
    chk("t5_tmo_clear_in_wait", 32'(bus.timeout_err), 32'd0);
    tick();
    chk("t5_reject", 32'(bus.reject), 32'b1000);
    chk("t5_tmo",    32'(bus.timeout_err), 32'd1);
    tick();
    bus.chk_done = 1'b1;
    tick();
    chk("t5_late_done", 32'({bus.grant, bus.reject, bus.busy}), 32'd0);
    bus.chk_done = 1'b0;
    chk("t5_moves", 32'(bus.moves_left), 32'd5);

    // Move rrPtr to 2, then reset while object 2 is in WAIT.
    serve("t6_pre", 4'b0010, 16'h0020, 1, 1'b0, 3'd1, 4'd2, 1'b0, lat);
    bus.move_req = 4'b0100;
    bus.move_dir = 16'h0200;
    waitStart("t6", lat);
    chk("t6_obj", 32'(bus.chk_obj), 32'd2);
    bus.move_req = '0;
    tick();
    chk("t6_in_wait", 32'(bus.busy), 32'd1);
    rst = 1'b1;
    #1;
    chk("t6_rst_busy",    32'(bus.busy), 32'd0);
    chk("t6_rst_tmo",     32'(bus.timeout_err), 32'd0);
    chk("t6_rst_obj_dir", 32'({bus.chk_obj, bus.chk_dir}), 32'd0);
    chk("t6_rst_moves",   32'(bus.moves_left), 32'd6);
    tick();
    rst = 1'b0;
    bus.chk_done = 1'b1;
    tick();
    chk("t6_done_ignored", 32'({bus.grant, bus.reject, bus.busy}), 32'd0);
    bus.chk_done = 1'b0;
    serve("t6_post", 4'b0101, 16'h0104, 1, 1'b0, 3'd0, 4'd4, 1'b0, lat);

    $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFail);
    $finish;
  end

endmodule
